// File: rtl/regfile_dbg_port_if.sv
// Debug access handshake bundle for the WISC register file.
// The host drives requests; the register file answers with responses.
interface regfile_dbg_port_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          dbg_req_valid;
    logic          dbg_req_ready;
    logic          dbg_req_write;
    logic [AW-1:0] dbg_req_addr;
    logic [DW-1:0] dbg_req_wdata;
    logic          dbg_rsp_valid;
    logic          dbg_rsp_ready;
    logic [DW-1:0] dbg_rsp_rdata;
    logic          dbg_rsp_err;

    modport master (
        output dbg_req_valid, dbg_req_write,
        output dbg_req_addr, dbg_req_wdata,
        output dbg_rsp_ready,
        input  dbg_req_ready, dbg_rsp_valid,
        input  dbg_rsp_rdata, dbg_rsp_err
    );

    modport slave (
        input  dbg_req_valid, dbg_req_write,
        input  dbg_req_addr, dbg_req_wdata,
        input  dbg_rsp_ready,
        output dbg_req_ready, dbg_rsp_valid,
        output dbg_rsp_rdata, dbg_rsp_err
    );
endinterface

// File: rtl/regfile_dbg_port.sv
// WISC 16x16 register file with a debug access port.
// Core ports keep priority; debug writes wait out core writeback.
module regfile_dbg_port #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 8,
    parameter int AW       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              writeReg,
    input  logic [AW-1:0]     dstReg,
    input  logic [DATA_W-1:0] dstData,
    input  logic [AW-1:0]     srcReg1,
    input  logic [AW-1:0]     srcReg2,
    output logic [DATA_W-1:0] srcData1,
    output logic [DATA_W-1:0] srcData2,
    regfile_dbg_port_if.slave dbg
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              dbg_we;
    logic              core_we;
    logic [DATA_W-1:0] regs_q [NUM_REGS];

    assign core_we = writeReg && (dstReg != '0);

    // R0 is never written, so reading the array already yields zero
    function automatic logic [DATA_W-1:0] rd_port(input logic [AW-1:0] a);
        if (core_we && (dstReg == a)) begin
            return dstData;
        end
        return regs_q[a];
    endfunction

    assign srcData1 = rd_port(srcReg1);
    assign srcData2 = rd_port(srcReg2);

    assign dbg.dbg_req_ready = (state_q == IDLE);
    assign dbg.dbg_rsp_valid = (state_q == RESP);
    assign dbg.dbg_rsp_rdata = rdata_q;
    assign dbg.dbg_rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        dbg_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dbg.dbg_req_valid) begin
                    wr_d    = dbg.dbg_req_write;
                    addr_d  = dbg.dbg_req_addr;
                    wdata_d = dbg.dbg_req_wdata;
                    wait_d  = '0;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!wr_q) begin
                    rdata_d = rd_port(addr_q);
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (addr_q == '0) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (!writeReg) begin
                    dbg_we  = 1'b1;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    wait_d = wait_q + WW'(1);
                    if (wait_d == WW'(MAX_WAIT)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dbg.dbg_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (core_we) begin
            regs_q[dstReg] <= dstData;
        end else if (dbg_we) begin
            regs_q[addr_q] <= wdata_q;
        end
    end
endmodule
